// File: rtl/sqrt_reduce_pkg.sv
// Shared constants, the reduction mode type and width helpers for the
// square-root reduction pipeline.
package sqrt_reduce_pkg;

    localparam int ISQRT_LAT = 16;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    function automatic int res_width(input int w, input int n_ch);
        return w / 2 + $clog2(n_ch);
    endfunction

    // Number of tree nodes entering level lvl: ceil(n_ch / 2**lvl).
    function automatic int nodes_at(input int n_ch, input int lvl);
        return (n_ch + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/isqrt.sv
// Pipelined integer square root, one root bit per stage, so the latency is W/2
// cycles. Only the valid bits are reset; data stages load when their valid is 1.
module isqrt #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           x_vld,
    input  logic [W-1:0]   x,
    output logic           y_vld,
    output logic [W/2-1:0] y
);

    localparam int H   = W / 2;
    localparam int RMW = H + 2;

    logic [H-1:0]   vld_q;
    logic [W-1:0]   x_q    [H-1];
    logic [RMW-1:0] rem_q  [H-1];
    logic [H-1:0]   root_q [H];
    logic [RMW-1:0] rem_d  [H];
    logic [H-1:0]   root_d [H];

    // Restoring step: bring down the next bit pair, subtract 4*root+1 if it fits.
    function automatic logic [RMW+H-1:0] sqrt_step(input logic [RMW-1:0] rem,
                                                   input logic [H-1:0]   root,
                                                   input logic [1:0]     pair);
        logic [RMW-1:0] cur;
        logic [RMW-1:0] trial;
        cur   = {rem[RMW-3:0], pair};
        trial = {root, 2'b01};
        if (cur >= trial)
            return {cur - trial, root[H-2:0], 1'b1};
        return {cur, root[H-2:0], 1'b0};
    endfunction

    always_comb begin
        {rem_d[0], root_d[0]} = sqrt_step('0, '0, x[W-1 -: 2]);
        for (int s = 1; s < H; s++)
            {rem_d[s], root_d[s]} = sqrt_step(rem_q[s-1], root_q[s-1], x_q[s-1][2*(H-1-s) +: 2]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_q <= '0;
        else
            vld_q <= {vld_q[H-2:0], x_vld};
    end

    always_ff @(posedge clk) begin
        if (x_vld) begin
            x_q[0]    <= x;
            rem_q[0]  <= rem_d[0];
            root_q[0] <= root_d[0];
        end
        for (int s = 1; s < H - 1; s++) begin
            if (vld_q[s-1]) begin
                x_q[s]    <= x_q[s-1];
                rem_q[s]  <= rem_d[s];
                root_q[s] <= root_d[s];
            end
        end
        if (vld_q[H-2])
            root_q[H-1] <= root_d[H-1];
    end

    assign y_vld = vld_q[H-1];
    assign y     = root_q[H-1];

endmodule

// File: rtl/sqrt_reduce_level.sv
// One registered level of the reduction tree: pairwise sum or max, odd node
// passed through; every output register is enabled by the incoming valid.
module sqrt_reduce_level
    import sqrt_reduce_pkg::*;
#(
    parameter  int N_IN  = 3,
    parameter  int NW    = 16,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int OW    = NW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  mode_e              in_mode,
    input  logic [N_IN*NW-1:0] in_data,
    output logic               out_vld,
    output mode_e              out_mode,
    output logic [N_OUT*OW-1:0] out_data
);

    logic [N_OUT*OW-1:0] nxt;

    for (genvar o = 0; o < N_OUT; o++) begin : g_node
        logic [NW-1:0] a;
        assign a = in_data[2*o*NW +: NW];
        if (2*o + 1 < N_IN) begin : g_pair
            logic [NW-1:0] b;
            assign b = in_data[(2*o+1)*NW +: NW];
            assign nxt[o*OW +: OW] = (in_mode == MODE_MAX) ? {1'b0, ((a > b) ? a : b)}
                                                           : {1'b0, a} + {1'b0, b};
        end else begin : g_pass
            assign nxt[o*OW +: OW] = {1'b0, a};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_vld <= 1'b0;
        else
            out_vld <= in_vld;
    end

    // Data is reset too so the final level presents 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mode <= MODE_SUM;
            out_data <= '0;
        end else if (in_vld) begin
            out_mode <= in_mode;
            out_data <= nxt;
        end
    end

endmodule

// File: rtl/sqrt_reduce_pipe.sv
// N_CH parallel integer square roots followed by a pipelined sum/max tree,
// with per-vector channel masking and a fixed latency of ISQRT_LAT + LVL.
module sqrt_reduce_pipe
    import sqrt_reduce_pkg::*;
#(
    parameter  int N_CH = 3,
    parameter  int W    = 32,
    localparam int RW   = res_width(W, N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arg_vld,
    input  logic [N_CH*W-1:0] arg,
    input  logic [N_CH-1:0]   arg_mask,
    input  logic              mode,
    output logic              res_vld,
    output logic [RW-1:0]     res
);

    localparam int H   = W / 2;
    localparam int LVL = $clog2(N_CH);

    logic [N_CH-1:0]   y_vld;
    logic [N_CH*H-1:0] roots;
    logic              grp_vld;

    // Masked channels feed a constant 0 so their datapath stays quiet.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [W-1:0] x_in;
        assign x_in = arg_mask[i] ? arg[i*W +: W] : '0;
        isqrt #(.W(W)) u_isqrt (
            .clk   (clk),
            .reset (!rst_n),
            .x_vld (arg_vld),
            .x     (x_in),
            .y_vld (y_vld[i]),
            .y     (roots[i*H +: H])
        );
    end

    assign grp_vld = &y_vld;

    logic [ISQRT_LAT-1:0] sb_vld;
    mode_e                sb_mode [ISQRT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_vld <= '0;
        else
            sb_vld <= {sb_vld[ISQRT_LAT-2:0], arg_vld};
    end

    always_ff @(posedge clk) begin
        if (arg_vld)
            sb_mode[0] <= mode_e'(mode);
        for (int i = 1; i < ISQRT_LAT; i++)
            if (sb_vld[i-1])
                sb_mode[i] <= sb_mode[i-1];
    end

    a_align : assert property (@(posedge clk) disable iff (!rst_n)
                               grp_vld == sb_vld[ISQRT_LAT-1]);

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int NI = nodes_at(N_CH, l);
        localparam int NW = H + l;
        localparam int NO = (NI + 1) / 2;
        logic              v;
        mode_e             m;
        logic [NO*(NW+1)-1:0] d;
        if (l == 0) begin : g_first
            sqrt_reduce_level #(.N_IN(NI), .NW(NW)) u_level (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_vld   (grp_vld),
                .in_mode  (sb_mode[ISQRT_LAT-1]),
                .in_data  (roots),
                .out_vld  (v),
                .out_mode (m),
                .out_data (d)
            );
        end else begin : g_next
            sqrt_reduce_level #(.N_IN(NI), .NW(NW)) u_level (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_vld   (g_lvl[l-1].v),
                .in_mode  (g_lvl[l-1].m),
                .in_data  (g_lvl[l-1].d),
                .out_vld  (v),
                .out_mode (m),
                .out_data (d)
            );
        end
    end

    assign res_vld = g_lvl[LVL-1].v;
    assign res     = g_lvl[LVL-1].d;

endmodule

// File: tb/tb_sqrt_reduce_pipe.sv
// Randomised bench for sqrt_reduce_pipe (N_CH = 3, 5, 2) against a plain
// arithmetic model of masked square-root sum/max at fixed latency.
module tb_sqrt_reduce_pipe;
    import sqrt_reduce_pkg::*;

    localparam int W     = 32;
    localparam int L3    = ISQRT_LAT + 2;
    localparam int L5    = ISQRT_LAT + 3;
    localparam int L2    = ISQRT_LAT + 1;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        arg_vld = 1'b0;
    logic [95:0] arg = '0;
    logic [2:0]  arg_mask = '0;
    logic        mode = 1'b0;
    logic        res_vld;
    logic [17:0] res;

    logic         vld5 = 1'b0;
    logic [159:0] arg5 = '0;
    logic         res5_vld;
    logic [18:0]  res5;

    logic         vld2 = 1'b0;
    logic [63:0]  arg2 = '0;
    logic         res2_vld;
    logic [16:0]  res2;

    sqrt_reduce_pipe #(.N_CH(3), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg(arg), .arg_mask(arg_mask),
        .mode(mode), .res_vld(res_vld), .res(res)
    );

    sqrt_reduce_pipe #(.N_CH(5), .W(W)) dut5 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld5), .arg(arg5), .arg_mask(5'b11111),
        .mode(1'b0), .res_vld(res5_vld), .res(res5)
    );

    sqrt_reduce_pipe #(.N_CH(2), .W(W)) dut2 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld2), .arg(arg2), .arg_mask(2'b11),
        .mode(1'b0), .res_vld(res2_vld), .res(res2)
    );

    int     cmpCount = 0;
    int     errCount = 0;
    int     cyc = 0;
    bit     exp3V [DEPTH];
    longint exp3R [DEPTH];
    bit     exp5V [DEPTH];
    longint exp5R [DEPTH];
    bit     exp2V [DEPTH];
    longint exp2R [DEPTH];

    // Largest r with r*r <= v, by binary search.
    function automatic longint refIsqrt(input longint v);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic longint refReduce(input logic [95:0] a, input logic [2:0] m, input bit md);
        longint acc = 0;
        longint r;
        for (int i = 0; i < 3; i++) begin
            r = m[i] ? refIsqrt(longint'(a[i*32 +: 32])) : 0;
            if (md) begin
                if (r > acc) acc = r;
            end else begin
                acc += r;
            end
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        cmpCount++;
        if (obs != exp) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock and compare every DUT against its schedule.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("res_vld", longint'(res_vld), longint'(exp3V[cyc]));
        if (exp3V[cyc]) checkOutput("res", longint'(res), exp3R[cyc]);
        checkOutput("res5_vld", longint'(res5_vld), longint'(exp5V[cyc]));
        if (exp5V[cyc]) checkOutput("res5", longint'(res5), exp5R[cyc]);
        checkOutput("res2_vld", longint'(res2_vld), longint'(exp2V[cyc]));
        if (exp2V[cyc]) checkOutput("res2", longint'(res2), exp2R[cyc]);
    endtask

    // fixedExp < 0 means take the expected value from the model.
    task automatic applyStimulus(input bit v, input logic [95:0] a, input logic [2:0] m,
                                 input bit md, input longint fixedExp);
        arg_vld  = v;
        arg      = a;
        arg_mask = m;
        mode     = md;
        if (v) begin
            exp3V[cyc + L3] = 1'b1;
            exp3R[cyc + L3] = (fixedExp >= 0) ? fixedExp : refReduce(a, m, md);
        end
        tick();
    endtask

    task automatic randomVector(input bit v);
        logic [95:0] a;
        for (int i = 0; i < 3; i++)
            a[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
        applyStimulus(v, a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        logic [95:0] abc;
        logic [95:0] full;
        abc  = {32'd36, 32'd25, 32'd16};
        full = {96{1'b1}};

        repeat (3) begin
            applyStimulus(1'b0, '0, '0, 1'b0, -1);
            checkOutput("reset_res", longint'(res), 0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, -1);

        $display("[TB] directed vectors");
        vld5 = 1'b1;
        arg5 = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        exp5V[cyc + L5] = 1'b1;
        exp5R[cyc + L5] = 15;
        vld2 = 1'b1;
        arg2 = {32'd1, 32'd0};
        exp2V[cyc + L2] = 1'b1;
        exp2R[cyc + L2] = 1;
        applyStimulus(1'b1, abc, 3'b111, 1'b0, 15);
        vld5 = 1'b0;
        vld2 = 1'b0;
        repeat (L5 + 2) applyStimulus(1'b0, '0, '0, 1'b0, -1);

        applyStimulus(1'b1, abc,  3'b111, 1'b1, 6);
        applyStimulus(1'b1, abc,  3'b010, 1'b0, 5);
        applyStimulus(1'b1, abc,  3'b000, 1'b0, 0);
        applyStimulus(1'b1, abc,  3'b000, 1'b1, 0);
        applyStimulus(1'b1, full, 3'b111, 1'b0, 196605);
        applyStimulus(1'b1, full, 3'b111, 1'b1, 65535);
        repeat (L3 + 2) applyStimulus(1'b0, '0, '0, 1'b0, -1);

        $display("[TB] random streaming");
        repeat (64) randomVector(1'b1);
        repeat (64) randomVector(1'($urandom_range(0, 1)));

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 10; i++) randomVector(1'b1);
        rst_n = 1'b0;
        arg_vld = 1'b0;
        #1;
        checkOutput("rst_vld_now", longint'(res_vld), 0);
        checkOutput("rst_res_now", longint'(res), 0);
        for (int t = cyc; t < DEPTH; t++) begin
            exp3V[t] = 1'b0;
            exp5V[t] = 1'b0;
            exp2V[t] = 1'b0;
        end
        repeat (2) begin
            applyStimulus(1'b0, '0, '0, 1'b0, -1);
            checkOutput("rst_res_hold", longint'(res), 0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b1, abc, 3'b111, 1'b0, 15);
        repeat (L3 + 3) applyStimulus(1'b0, '0, '0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
